// File: rtl/aes_pkg.sv
`timescale 1ns/1ps
// aes_pkg: definitions shared by the AES forward and inverse cipher blocks.
// Holds the block width, the inverse-cipher state encoding, the inverse
// S-box and the GF(2^8) multiply helpers used by both mixcolumns flavours.
package aes_pkg;

  localparam int AES_BLOCK_W = 128;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2,
    ST_HOLD  = 2'd3
  } inv_state_e;

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // Multiply by x modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul2(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // General GF(2^8) multiply by shift-and-add; constant b folds away.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h00;
    p   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ p;
      p = gf_mul2(p);
    end
    return acc;
  endfunction

endpackage

// File: rtl/aes_inv_mixcolumns.sv
`timescale 1ns/1ps
// aes_inv_mixcolumns: combinational InvMixColumns over a full 128-bit state.
// Column c occupies bytes 4c..4c+3, byte 0 in the most significant position.
module aes_inv_mixcolumns
  import aes_pkg::*;
(
  input  logic [AES_BLOCK_W-1:0] state,
  output logic [AES_BLOCK_W-1:0] mixed
);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_col
      logic [7:0] a0, a1, a2, a3;
      assign a0 = state[AES_BLOCK_W-1-32*gi      -: 8];
      assign a1 = state[AES_BLOCK_W-1-32*gi - 8  -: 8];
      assign a2 = state[AES_BLOCK_W-1-32*gi - 16 -: 8];
      assign a3 = state[AES_BLOCK_W-1-32*gi - 24 -: 8];

      // Circulant matrix rows {0e,0b,0d,09} rotated per output byte.
      assign mixed[AES_BLOCK_W-1-32*gi -: 8] =
        gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      assign mixed[AES_BLOCK_W-1-32*gi - 8 -: 8] =
        gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      assign mixed[AES_BLOCK_W-1-32*gi - 16 -: 8] =
        gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      assign mixed[AES_BLOCK_W-1-32*gi - 24 -: 8] =
        gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
  endgenerate

endmodule

// File: rtl/aes_inv_cipher.sv
`timescale 1ns/1ps
// aes_inv_cipher: iterative AES decryption, one inverse round per clock.
// Round keys are fetched from an external key store, index NR down to 0,
// with the key data arriving combinationally in the same cycle.
// Optional macro AES_INV_CIPHER_ZEROIZE_EN clears the block register on the
// output handshake so no plaintext lingers after delivery.
module aes_inv_cipher
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_BLOCK_W-1:0] in_data,
  output logic [3:0]             rk_idx,
  input  logic [AES_BLOCK_W-1:0] rk_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_BLOCK_W-1:0] out_data
);

  localparam logic [3:0] NR_IDX    = 4'(NR);
  localparam logic [3:0] RND_FIRST = 4'(NR - 1);

  inv_state_e             state_reg, state_next;
  logic [3:0]             rnd_reg, rnd_next;
  logic [AES_BLOCK_W-1:0] stm_reg, stm_next;

  logic [AES_BLOCK_W-1:0] shifted;
  logic [AES_BLOCK_W-1:0] subbed;
  logic [AES_BLOCK_W-1:0] keyed;
  logic [AES_BLOCK_W-1:0] mixed;

  // InvShiftRows (row r rotated right by r columns) then InvSubBytes, per byte.
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_byte
      localparam int COL = gi / 4;
      localparam int ROW = gi % 4;
      localparam int SRC = 4 * ((COL + 4 - ROW) % 4) + ROW;
      assign shifted[AES_BLOCK_W-1-8*gi -: 8] = stm_reg[AES_BLOCK_W-1-8*SRC -: 8];
      assign subbed[AES_BLOCK_W-1-8*gi -: 8]  = INV_SBOX[shifted[AES_BLOCK_W-1-8*gi -: 8]];
    end
  endgenerate

  assign keyed = subbed ^ rk_data;

  aes_inv_mixcolumns u_inv_mix (
    .state (keyed),
    .mixed (mixed)
  );

  // State, round counter and block register; reset abandons any block in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      rnd_reg   <= 4'd0;
      stm_reg   <= '0;
    end else begin
      state_reg <= state_next;
      rnd_reg   <= rnd_next;
      stm_reg   <= stm_next;
    end
  end

  // Next-state, round-key index, datapath select and handshake outputs.
  always_comb begin
    state_next = state_reg;
    rnd_next   = rnd_reg;
    stm_next   = stm_reg;
    in_ready   = 1'b0;
    rk_idx     = 4'd0;
    out_valid  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        // in_ready and rk_idx stay low while reset is held.
        in_ready = reset;
        rk_idx   = reset ? NR_IDX : 4'd0;
        if (in_valid && reset) begin
          stm_next   = in_data ^ rk_data;
          rnd_next   = RND_FIRST;
          state_next = ST_ROUND;
        end
      end
      ST_ROUND: begin
        rk_idx   = rnd_reg;
        stm_next = mixed;
        rnd_next = rnd_reg - 4'd1;
        if (rnd_reg == 4'd1) state_next = ST_FINAL;
      end
      ST_FINAL: begin
        rk_idx     = 4'd0;
        stm_next   = keyed;
        state_next = ST_HOLD;
      end
      ST_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = ST_IDLE;
`ifdef AES_INV_CIPHER_ZEROIZE_EN
          stm_next   = '0;
`else
          stm_next   = stm_reg;
`endif
        end
      end
      default: begin
        // Corrupted encoding: return to IDLE, block register left as is.
        state_next = ST_IDLE;
      end
    endcase
  end

  assign out_data = stm_reg;

endmodule
